// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default bus widths,
// starvation counter width and the encoding of the returning-read owner tag.
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  // Wide enough for the largest legal STARVE_LIMIT (15).
  localparam int unsigned STARVE_CNT_W = 4;

  // Owner of the read whose data returns from the BRAM in the next cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DBG  = 2'd2
  } rd_tag_e;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of BRAM port B.
// The CPU has priority; a starvation counter forces the debug requester
// through after STARVE_LIMIT consecutive denied cycles. Reads have a
// one-cycle latency and are routed back by a registered owner tag.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  (in)      CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata   CPU grant (combinational), read return
//   dbg_*                            debug requester, same as CPU port
//   mem_en/we/addr/din     (out)     BRAM port B controls (combinational)
//   mem_dout               (in)      BRAM port B read data
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  rd_tag_e                 tag_q, tag_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    force_dbg;

  // Grant decision; grants are suppressed while reset is asserted.
  always_comb begin : arb_comb
    force_dbg = dbg_req && (starve_q == STARVE_CNT_W'(STARVE_LIMIT));
    cpu_gnt   = rst_n && cpu_req && !force_dbg;
    dbg_gnt   = rst_n && dbg_req && (!cpu_req || force_dbg);
  end

  // Port B mux; address and write data hold their last granted values when idle.
  always_comb begin : mux_comb
    mem_en = cpu_gnt || dbg_gnt;
    mem_we = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    tag_d  = TAG_NONE;
    if (dbg_gnt) begin
      mem_we = dbg_we;
      addr_d = dbg_addr;
      din_d  = dbg_wdata;
      tag_d  = dbg_we ? TAG_NONE : TAG_DBG;
    end else if (cpu_gnt) begin
      mem_we = cpu_we;
      addr_d = cpu_addr;
      din_d  = cpu_wdata;
      tag_d  = cpu_we ? TAG_NONE : TAG_CPU;
    end
    mem_addr = addr_d;
    mem_din  = din_d;
  end

  // Starvation counter: counts denied debug cycles, saturating at the limit.
  always_comb begin : starve_comb
    starve_d = starve_q;
    if (!dbg_req || dbg_gnt) begin
      starve_d = '0;
    end else if (starve_q < STARVE_CNT_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_CNT_W'(1);
    end
  end

  // Read return routing by owner tag; non-owners see zero data.
  always_comb begin : rd_comb
    cpu_rvalid = (tag_q == TAG_CPU);
    dbg_rvalid = (tag_q == TAG_DBG);
    cpu_rdata  = cpu_rvalid ? mem_dout : '0;
    dbg_rdata  = dbg_rvalid ? mem_dout : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_ff
    if (!rst_n) begin
      starve_q <= '0;
      tag_q    <= TAG_NONE;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 9, word address width of BRAM port B.
REQ-002 Parameter DATA_WIDTH, 16, data word width.
REQ-003 Parameter STARVE_LIMIT, 4, number of consecutive denied cycles after which the debug requester is forced through (legal range 1..15).
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req, cpu_we  in  1 each  CPU (FSM) data-memory request and write enable.
REQ-007 cpu_addr  in  ADDR_WIDTH  CPU word address.
REQ-008 cpu_wdata  in  DATA_WIDTH  CPU write data.
REQ-009 cpu_gnt  out  1  CPU access accepted this cycle.
REQ-010 cpu_rvalid  out  1  CPU read data valid.
REQ-011 cpu_rdata  out  DATA_WIDTH  CPU read data.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: debug/memory-display requester, same widths and meanings as the CPU port.
REQ-013 mem_en, mem_we  out  1 each  BRAM port B enable and write enable.
REQ-014 mem_addr  out  ADDR_WIDTH;  mem_din  out  DATA_WIDTH;  mem_dout  in  DATA_WIDTH  BRAM port B address, write data and read data.

Function
REQ-015 Requesters hold req, we, addr and wdata stable from req assertion until the cycle gnt is high; the access completes in that cycle.
REQ-016 Grants are combinational from the current req inputs and registered arbitration state; at most one gnt is high per cycle.
REQ-017 Default priority: CPU wins when both requests are high.
REQ-018 The starvation counter increments, saturating at STARVE_LIMIT, each cycle dbg_req=1 and dbg_gnt=0; it clears when dbg_gnt=1 or dbg_req=0.
REQ-019 When the counter equals STARVE_LIMIT and dbg_req=1, the debug requester is granted even if cpu_req=1; the CPU is then denied that cycle and retries.
REQ-020 In a grant cycle: mem_en=1, and mem_we, mem_addr and mem_din are muxed from the granted requester.
REQ-021 With no grant: mem_en=0 and mem_we=0; mem_addr and mem_din hold their previous muxed values (no toggling).
REQ-022 Read latency is 1 cycle: the cycle after a granted read (we=0), the owner's rvalid=1 and its rdata=mem_dout.
REQ-023 A granted write produces no rvalid.
REQ-024 Ownership of the returning read is a registered 2-bit tag (none/cpu/dbg), so back-to-back reads by alternating requesters return correctly on consecutive cycles.
REQ-025 rdata of a non-owner, and of any port while its rvalid=0, is zero.
REQ-026 Requests with req=0 never affect memory, the tag or rvalid, whatever the other fields carry.

Reset
REQ-027 While rst_n=0: all gnt, rvalid, mem_en and mem_we outputs are 0; mem_addr and mem_din are 0; the starvation counter and read tag clear.
REQ-028 Reset asserted during an outstanding read drops that read; no rvalid follows after reset release.
REQ-029 The first grant is possible in the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package holds ADDR_WIDTH/DATA_WIDTH defaults and the read-tag encoding constants (TAG_NONE=0, TAG_CPU=1, TAG_DBG=2).
REQ-031 The block is a single module with no sub-modules; the BRAM stays external and connects to port B.

Verification
REQ-032 Preload mem[100]=5. CPU reads 100 with no debug traffic -> cpu_gnt in the same cycle, cpu_rvalid=1 and cpu_rdata=5 one cycle later; dbg_rvalid stays 0.
REQ-033 CPU writes 7 to addr 200 in cycle N, debug reads 200 in cycle N+1 -> dbg_rdata=7 at N+2; no cpu_rvalid is raised.
REQ-034 cpu_req and dbg_req held high continuously, STARVE_LIMIT=4 -> CPU is granted 4 cycles, then debug 1 cycle, repeating; the counter never exceeds 4.
REQ-035 Alternating CPU and debug reads of addresses 100/101 (data 5/7) on consecutive cycles -> each rvalid/rdata lands on the correct port one cycle after its grant.
REQ-036 rst_n pulsed low for 1 cycle immediately after a granted CPU read -> no cpu_rvalid after release; all outputs are 0 during reset.
REQ-037 dbg_req is dropped after 3 denied cycles and then re-raised -> the counter restarts from 0, so debug is granted only after 4 more denied cycles.
